// File: rtl/gmux_pkg.sv
// gmux_pkg: shared types, sizes and helpers for the sequenced N-input
// clock multiplexer controller (gmux_switch_ctrl).
package gmux_pkg;

    // Controller states: IDLE accepts requests, DRAIN holds all enables low,
    // ENABLE is the single commit cycle in which the new input is live.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        ENABLE = 2'd2
    } state_t;

    // Width of the dead-time counter (covers SETTLE_CYCLES up to 15).
    localparam int CNT_W = 4;

    // Largest supported input count; onehot() returns this many bits.
    localparam int MAX_INPUTS = 16;

    // One-hot decode of idx; all-zero when idx is outside 0..n-1.
    function automatic logic [MAX_INPUTS-1:0] onehot(input logic [3:0] idx, input int n);
        logic [MAX_INPUTS-1:0] v;
        v = {MAX_INPUTS{1'b0}};
        if (int'(idx) < n) begin
            v[idx] = 1'b1;
        end else begin
            v = {MAX_INPUTS{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/gmux_settle_cnt.sv
// gmux_settle_cnt: loadable down-counter with a zero flag. It times the
// all-off dead time between two enables of the clock multiplexer.
module gmux_settle_cnt #(
    parameter int CNT_W = gmux_pkg::CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; decrement holds at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/gmux_switch_ctrl.sv
// gmux_switch_ctrl: N-input clock multiplexer with a break-before-make
// select controller. A switch request drops every enable, waits
// SETTLE_CYCLES with all inputs off, then enables the new input and pulses
// DONE. Selecting the current input is a no-op (DONE next cycle); selecting
// a non-existent input is rejected (ERR next cycle).
// Optional build macro GMUX_SWITCH_COUNT_EN adds SWITCH_CNT, a 16-bit
// wrapping count of completed real switches.
module gmux_switch_ctrl
    import gmux_pkg::*;
#(
    parameter int NUM_INPUTS    = 4,
    parameter int SEL_W         = $clog2(NUM_INPUTS),
    parameter int SETTLE_CYCLES = 2,
    parameter int DEFAULT_SEL   = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    (* ASYNC_CLOCK = "TRUE" *)
    input  logic [NUM_INPUTS-1:0] IN,
    input  logic                  REQ_VALID,
    input  logic [SEL_W-1:0]      REQ_SEL,
    output logic                  REQ_READY,
    output logic [NUM_INPUTS-1:0] EN,
    output logic [SEL_W-1:0]      CUR_SEL,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
`ifdef GMUX_SWITCH_COUNT_EN
    output logic [15:0]           SWITCH_CNT,
`endif
    output logic                  IZ
);

    // Reset image of the enables and the select, and loop constants.
    localparam logic [NUM_INPUTS-1:0] EN_RST    = NUM_INPUTS'(onehot(4'(DEFAULT_SEL), NUM_INPUTS));
    localparam logic [SEL_W-1:0]      SEL_RST   = SEL_W'(DEFAULT_SEL);
    localparam logic [SEL_W:0]        NUM_IN_L  = (SEL_W+1)'(NUM_INPUTS);
    localparam logic [CNT_W-1:0]      SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SEL_W-1:0]      r_target;
    logic [SEL_W-1:0]      r_cur_sel;
    logic [SEL_W-1:0]      w_cur_sel_nxt;
    logic [NUM_INPUTS-1:0] r_en;
    logic [NUM_INPUTS-1:0] w_en_nxt;
    logic [NUM_INPUTS-1:0] w_target_oh;
    logic                  r_done;
    logic                  r_err;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_req_bad;
    logic                  w_req_same;
    logic                  w_switch;
    logic                  w_commit;
    logic                  w_cnt_zero;
    logic                  w_ready;
    logic                  w_busy;

    // Request classification; only IDLE accepts, so no queueing is possible.
    assign w_idle      = (r_state == IDLE);
    assign w_accept    = REQ_VALID & w_idle;
    assign w_req_bad   = ({1'b0, REQ_SEL} >= NUM_IN_L);
    assign w_req_same  = (REQ_SEL == r_cur_sel);
    assign w_switch    = w_accept & ~w_req_bad & ~w_req_same;
    assign w_commit    = (r_state == DRAIN) & w_cnt_zero;
    assign w_target_oh = NUM_INPUTS'(onehot(4'(r_target), NUM_INPUTS));

    // Dead-time counter: loaded on switch acceptance, counts down in DRAIN.
    gmux_settle_cnt #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_switch),
        .i_load_val (SETTLE_LD),
        .i_dec      (r_state == DRAIN),
        .o_zero     (w_cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_switch) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ENABLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            ENABLE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
            DRAIN, ENABLE: begin
                w_ready = 1'b0;
                w_busy  = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
                w_busy  = 1'b1;
            end
        endcase
    end

    // Next values of the enable/select/pulse registers.
    always_comb begin
        w_en_nxt      = r_en;
        w_cur_sel_nxt = r_cur_sel;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        if (w_accept) begin
            if (w_req_bad) begin
                w_err_nxt = 1'b1;
            end else if (w_req_same) begin
                w_done_nxt = 1'b1;
            end else begin
                // Break first: every input goes off before the new one is on.
                w_en_nxt = {NUM_INPUTS{1'b0}};
            end
        end else if (w_commit) begin
            // Make: the target and the reported select change together.
            w_en_nxt      = w_target_oh;
            w_cur_sel_nxt = r_target;
            w_done_nxt    = 1'b1;
        end else begin
            w_en_nxt      = r_en;
            w_cur_sel_nxt = r_cur_sel;
        end
    end

    // Enable, select and pulse registers; reset lands on the default input.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_en      <= EN_RST;
            r_cur_sel <= SEL_RST;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_en      <= w_en_nxt;
            r_cur_sel <= w_cur_sel_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Latch the requested target when a real switch is accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_target <= SEL_RST;
        end else if (w_switch) begin
            r_target <= REQ_SEL;
        end else begin
            r_target <= r_target;
        end
    end

`ifdef GMUX_SWITCH_COUNT_EN
    logic [15:0] r_switch_cnt;

    // Count completed real switches; wraps from 0xFFFF to 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_switch_cnt <= 16'd0;
        end else if (w_commit) begin
            r_switch_cnt <= r_switch_cnt + 16'd1;
        end else begin
            r_switch_cnt <= r_switch_cnt;
        end
    end

    assign SWITCH_CNT = r_switch_cnt;
`endif

    assign REQ_READY = w_ready;
    assign BUSY      = w_busy;
    assign EN        = r_en;
    assign CUR_SEL   = r_cur_sel;
    assign DONE      = r_done;
    assign ERR       = r_err;
    assign IZ        = |(IN & r_en);

endmodule
